// File: rtl/trojan_cap_pkg.sv
// trojan_cap_pkg: shared types and constants for the trojan response-capture stage.
//   state_t      - sweep controller states (IDLE, RUN, DONE)
//   DEF_POLY     - default MISR feedback polynomial (16-bit CRC-CCITT taps)
//   DEF_SEED     - default MISR start value
//   misr_next()  - one MISR step for a 16-bit register, for use by reference models
package trojan_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // Shift left, fold the bit shifted out back in through the polynomial,
    // then absorb the new data word.
    function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                              input logic [15:0] data,
                                              input logic [15:0] poly);
        return (sig << 1) ^ (sig[15] ? poly : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// misr_reg: multiple-input signature register.
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (loads SEED)
//   clear_i  in   synchronous reload of SEED; has priority over enable_i
//   enable_i in   absorb data_i this cycle
//   data_i   in   SIG_W  word to compact
//   sig_o    out  SIG_W  current signature
module misr_reg #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q, sig_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = SEED;
        end else if (enable_i) begin
            sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/trojan_resp_capture.sv
// trojan_resp_capture: on-chip response checker for a trojan-test sweep.
// Compacts {pat,resp} into a MISR, counts resp/exp_resp mismatches, records
// the first failing vector and flags a trojan at end of sweep.
//   CK             in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   start          in   begin a new sweep (ignored while running)
//   sample         in   pat/resp/exp_resp valid this cycle
//   pat            in   N_IN   pattern applied to the DUT
//   resp           in   OUT_W  DUT response
//   exp_resp       in   OUT_W  golden response
//   busy           out  sweep in progress
//   done           out  sweep complete, results valid
//   signature      out  SIG_W  MISR contents
//   mismatch_cnt   out  CNT_W  saturating mismatch count
//   first_fail_idx out  N_IN   sample index of first mismatch
//   first_fail_pat out  N_IN   pattern at first mismatch
//   trojan_flag    out  done && mismatch_cnt != 0
module trojan_resp_capture
    import trojan_cap_pkg::*;
#(
    parameter int               N_IN  = 2,
    parameter int               OUT_W = 1,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    parameter int               CNT_W = 8
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             sample,
    input  logic [N_IN-1:0]  pat,
    input  logic [OUT_W-1:0] resp,
    input  logic [OUT_W-1:0] exp_resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [N_IN-1:0]  first_fail_idx,
    output logic [N_IN-1:0]  first_fail_pat,
    output logic             trojan_flag
);

    state_t           state_q, state_d;
    logic             sweep_clear;   // start accepted: reload everything
    logic             sweep_step;    // sample accepted in RUN
    logic             is_mismatch;
    logic             last_vec;

    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  ffi_q, ffi_d;
    logic [N_IN-1:0]  ffp_q, ffp_d;
    logic             seen_q, seen_d;

    assign is_mismatch = (resp != exp_resp);
    assign last_vec    = (idx_q == {N_IN{1'b1}});

    // Controller. start takes priority over sample outside RUN, and both
    // sample and start are otherwise ignored outside their own states.
    always_comb begin
        state_d     = state_q;
        sweep_clear = 1'b0;
        sweep_step  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sweep_clear = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (sample) begin
                    sweep_step = 1'b1;
                    if (last_vec) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters and first-fail capture.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        ffi_d  = ffi_q;
        ffp_d  = ffp_q;
        seen_d = seen_q;
        if (sweep_clear) begin
            idx_d  = '0;
            cnt_d  = '0;
            ffi_d  = '0;
            ffp_d  = '0;
            seen_d = 1'b0;
        end else if (sweep_step) begin
            // Natural wrap of the index coincides with the move to DONE.
            idx_d = idx_q + 1'b1;
            if (is_mismatch) begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                if (!seen_q) begin
                    ffi_d  = idx_q;
                    ffp_d  = pat;
                    seen_d = 1'b1;
                end
            end
        end
    end

    // NOTE: every control and result register is reset asynchronously so a mid-sweep reset leaves no partial results.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ffi_q   <= '0;
            ffp_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ffi_q   <= ffi_d;
            ffp_q   <= ffp_d;
            seen_q  <= seen_d;
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk_i    (CK),
        .rst_ni   (reset),
        .clear_i  (sweep_clear),
        .enable_i (sweep_step),
        .data_i   (SIG_W'({pat, resp})),
        .sig_o    (signature)
    );

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign mismatch_cnt   = cnt_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_pat = ffp_q;
    assign trojan_flag    = done && (cnt_q != '0);

endmodule

// File: doc/trojan_resp_capture.md
Name: trojan_resp_capture

Overview:
- Downstream response-capture stage for a small combinational or sequential benchmark under trojan test.
- Consumes the DUT output once per applied pattern, together with the pattern itself and the golden (expected) response.
- Compacts the pattern and response into a MISR signature and counts mismatches against the golden stream.
- Records the first failing vector and raises a trojan flag at end of sweep, replacing file-dump comparison with on-chip checking.

Parameters:
N_IN, 2, DUT input width (sweep length = 2**N_IN vectors)
OUT_W, 1, DUT output width
SIG_W, 16, MISR width; must satisfy N_IN+OUT_W <= SIG_W
POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)
SEED, 16'h0000, MISR value loaded on start
CNT_W, 8, mismatch counter width (saturating)

Ports:
CK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a new sweep
sample  in  1  strobe: pat/resp/exp_resp valid and stable this cycle
pat  in  N_IN  pattern currently applied to DUT
resp  in  OUT_W  DUT response for pat
exp_resp  in  OUT_W  golden response for pat
busy  out  1  sweep in progress
done  out  1  sweep complete; results valid
signature  out  SIG_W  MISR contents
mismatch_cnt  out  CNT_W  number of mismatching samples, saturates at all-ones
first_fail_idx  out  N_IN  sample index of first mismatch
first_fail_pat  out  N_IN  pattern value at first mismatch
trojan_flag  out  1  done && mismatch_cnt != 0

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs 0; signature = SEED; vector index = 0; first-fail-seen latch cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --sample on index 2**N_IN-1--> DONE.
  - DONE --start--> RUN.
- On start (from IDLE or DONE), registered the same cycle:
  - signature <= SEED; mismatch_cnt, index, first_fail_* and the seen latch cleared.
  - done <= 0; busy <= 1.
- In RUN, on each sample:
  - MISR update: d = zero-extended {pat,resp}; sig' = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ d.
  - If resp != exp_resp: mismatch_cnt += 1, saturating at 2**CNT_W-1. If the seen latch is clear, also capture first_fail_idx <= index and first_fail_pat <= pat, then set the latch.
  - index += 1. The increment wraps only at the final vector, where the FSM goes to DONE.
- Latency: every register update is visible the cycle after the sample. done, busy=0 and trojan_flag all go high the cycle after the final sample.
- sample in IDLE or DONE: ignored; no register changes.
- start in RUN: ignored; the sweep continues.
- start and sample in the same cycle in IDLE/DONE: start wins; the sample is dropped.
- Results in DONE hold until the next start or reset.
- Reset asserted mid-sweep: immediate return to IDLE with reset values; no partial results retained.
- first_fail_* stay 0 when no mismatch has occurred; trojan_flag distinguishes a real index-0 failure.

Decomposition:
- Shared package trojan_cap_pkg:
  - state enum (IDLE, RUN, DONE);
  - default POLY and SEED constants;
  - a MISR next-state function usable by bench models.
- One sub-module, misr_reg (parameters SIG_W, POLY, SEED; ports: clear, enable, data in, signature out).
- FSM, counters and first-fail capture stay in the top module.

Test Plan:
- N_IN=2, OUT_W=1. start, then 4 samples with pat 00,01,10,11, resp=exp_resp=0,0,0,0 -> signature 16'h0006, mismatch_cnt 0, done=1 the cycle after the 4th sample, trojan_flag 0.
- resp=exp_resp=0,1,1,0 -> signature 16'h0000, mismatch_cnt 0, trojan_flag 0.
- exp 0,1,1,0, resp 0,1,0,0 -> mismatch_cnt 1, first_fail_idx 2, first_fail_pat 2'b10, trojan_flag 1.
- exp all 0, resp all 1 -> mismatch_cnt 4, first_fail_idx 0, first_fail_pat 00, trojan_flag 1.
- Pulse reset low after the 2nd sample -> busy 0, signature SEED, counters 0. start again plus 4 clean samples -> done=1 and results identical to the first scenario.
- sample pulses before start and after done, plus start asserted mid-RUN -> no change to signature or counts; sweep still completes after exactly 4 in-RUN samples.
